// File: rtl/uart_fifo.sv
// Byte FIFO between UART receiver and transmitter, first-word-fall-through.
// Define UART_FIFO_STATS_EN to enable the drop_count/max_count statistics.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   max_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             push;
    logic             pop;
    logic             drop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr];
    assign count    = cnt;
    assign overflow = ovf;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = wr_en & (~full | rd_ack);
    assign pop  = rd_ack & ~empty;
    assign drop = wr_en & full & ~rd_ack;

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // A drop wins over a clear in the same cycle.
            if (drop)
                ovf <= 1'b1;
            else if (clr_overflow)
                ovf <= 1'b0;
        end
    end

`ifdef UART_FIFO_STATS_EN
    logic [15:0]   drop_q;
    logic [CW-1:0] max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
            max_q  <= '0;
        end else begin
            if (drop && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            if (cnt > max_q)
                max_q <= cnt;
        end
    end

    assign drop_count = drop_q;
    assign max_count  = max_q;
`else
    assign drop_count = '0;
    assign max_count  = '0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed table and sequence checks for uart_fifo at DEPTH=16, WIDTH=8.
module tb_uart_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ack = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic [15:0] drop_count;
    logic [4:0] max_count;

    int n_vec = 0;
    int n_err = 0;

    uart_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ack(rd_ack),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .clr_overflow(clr_overflow),
        .drop_count(drop_count), .max_count(max_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] d;
        logic       ack;
        logic       clr;
        int         cnt;
        logic       valid;
        logic [7:0] data;
        logic       chk;
        logic       ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input logic a, input logic c);
        @(negedge clk);
        rst = r; wr_en = w; wr_data = d; rd_ack = a; clr_overflow = c;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_ack = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, int'(rd_data), int'(exp));
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].ack, tbl[i].clr);
            n_vec++;
            if (int'(count) != tbl[i].cnt || rd_valid != tbl[i].valid ||
                empty != (tbl[i].cnt == 0) || full != (tbl[i].cnt == 16) ||
                overflow != tbl[i].ovf ||
                (tbl[i].chk && rd_data != tbl[i].data)) begin
                n_err++;
                $display("FAIL vec%0d: cnt=%0d valid=%b data=%h ovf=%b exp cnt=%0d valid=%b data=%h ovf=%b",
                         i, count, rd_valid, rd_data, overflow,
                         tbl[i].cnt, tbl[i].valid, tbl[i].data, tbl[i].ovf);
            end
        end

        // Fill and wrap.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        for (int i = 0; i < 4; i++) pop_chk("wrap_pop_a", 8'(i));
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        chk("wrap_full", int'(full), 1);
        for (int i = 0; i < 16; i++) pop_chk("wrap_pop_b", 8'(8'h04 + i));
        chk("wrap_empty", int'(empty), 1);

        // Overflow.
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'hFF);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        chk("ovf_head", int'(rd_data), 8'h20);
`ifdef UART_FIFO_STATS_EN
        chk("drop_cnt1", int'(drop_count), 1);
        chk("max_cnt", int'(max_count), 16);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", int'(overflow), 0);
        step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
        chk("ovf_drop_vs_clr", int'(overflow), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr2", int'(overflow), 0);
`ifdef UART_FIFO_STATS_EN
        chk("drop_cnt2", int'(drop_count), 2);
`endif

        // Push and pop together while full.
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("fsim_count", int'(count), 16);
        chk("fsim_ovf", int'(overflow), 0);
        for (int i = 1; i < 16; i++) pop_chk("fsim_pop", 8'(8'h20 + i));
        pop_chk("fsim_last", 8'h55);
        chk("fsim_empty", int'(empty), 1);

        // Reset mid-operation with overflow set and 7 entries held.
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        push(8'hFF);
        for (int i = 0; i < 9; i++) pop_chk("rst_pre_pop", 8'(8'h40 + i));
        chk("rst_pre_count", int'(count), 7);
        chk("rst_pre_ovf", int'(overflow), 1);
        step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_max", int'(max_count), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_not_stored", int'(count), 0);
        push(8'h77);
        chk("post_rst_data", int'(rd_data), 8'h77);
        chk("post_rst_count", int'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16; the number of byte entries, a power of two, 2..256.
REQ-002 SHALL have parameter WIDTH, default 8; the data width in bits.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit; a one-cycle push strobe, driven by the receiver's data_ready.
REQ-006 SHALL have port wr_data, input, WIDTH bits; the byte to push, sampled when wr_en=1.
REQ-007 SHALL have port rd_valid, output, 1 bit; high while the FIFO is not empty, and feeds the transmitter's en.
REQ-008 SHALL have port rd_data, output, WIDTH bits; the head entry, first-word-fall-through.
REQ-009 SHALL have port rd_ack, input, 1 bit; a one-cycle pop strobe, driven by the transmitter's rdy.
REQ-010 SHALL have port count, output, clog2(DEPTH)+1 bits; the current occupancy.
REQ-011 SHALL have ports full and empty, output, 1 bit each; occupancy flags.
REQ-012 SHALL have port overflow, output, 1 bit; a sticky flag set when a byte is dropped.
REQ-013 SHALL have port clr_overflow, input, 1 bit; clears overflow.
REQ-014 SHALL have port drop_count, output, 16 bits; the number of dropped bytes, defined in REQ-030.
REQ-015 SHALL have port max_count, output, same width as count; the occupancy high-water mark, defined in REQ-030.

Function
REQ-016 SHALL store entries in a DEPTH-entry circular array with read and write pointers of clog2(DEPTH) bits each, wrapping from DEPTH-1 to 0.
REQ-017 SHALL accept a push on wr_en=1 when full=0: the byte is written at the write pointer, the write pointer increments, and count increments.
REQ-018 SHALL perform a pop on rd_ack=1 when empty=0: the read pointer increments and count decrements.
REQ-019 SHALL ignore rd_ack when empty=1, with no pointer or count change.
REQ-020 SHALL have push-to-output latency of 1 cycle: a push at edge N into an empty FIFO gives rd_valid=1 and rd_data=the pushed byte after edge N.
REQ-021 SHALL keep rd_data equal to the array entry at the read pointer; rd_data is don't-care while empty=1.
REQ-022 SHALL handle wr_en and rd_ack together with 0<count<DEPTH as both operations performed, with count unchanged.
REQ-023 SHALL handle wr_en and rd_ack together with count=DEPTH as pop and push both performed, count stays DEPTH, and overflow is not set.
REQ-024 SHALL handle wr_en and rd_ack together with count=0 as push accepted, rd_ack ignored, and count=1.
REQ-025 SHALL, on wr_en with full=1 and no rd_ack, drop the byte, leave contents unchanged, and set overflow=1 on the next edge.
REQ-026 SHALL hold overflow until rst=1 or clr_overflow=1; if a drop and clr_overflow occur in the same cycle, overflow=1.
REQ-027 SHALL drive full=(count==DEPTH), empty=(count==0), and rd_valid=~empty, all registered-state derived with no combinational path from inputs.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, clear both pointers, count=0, empty=1, full=0, rd_valid=0, overflow=0, drop_count=0, and max_count=0; array contents are not cleared.
REQ-029 SHALL give rst priority over wr_en, rd_ack, and clr_overflow in the same cycle; a reset mid-stream discards all stored bytes.

Configuration
REQ-030 SHALL, with macro UART_FIFO_STATS_EN defined, increment drop_count on every dropped byte, saturating at 16'hFFFF, and update max_count to count whenever count exceeds it; neither is cleared by clr_overflow.
REQ-031 SHALL, with UART_FIFO_STATS_EN undefined, keep the drop_count and max_count ports present but tied to constant 0, with no statistics registers synthesised; all other behaviour is identical.

Verification
REQ-032 SHALL cover single-byte fall-through: after rst, push 8'hA5 -> the next cycle gives rd_valid=1, rd_data=8'hA5, count=1; then rd_ack -> empty=1, count=0.
REQ-033 SHALL cover fill and wrap: DEPTH=16, push 8'h00..8'h0F -> full=1; pop 4, push 8'h10..8'h13 -> the popped sequence is 8'h04..8'h13 in order and empty=1 at the end.
REQ-034 SHALL cover overflow: with full=1, push 8'hFF without rd_ack -> overflow=1, count=16, head unchanged; clr_overflow -> overflow=0; with STATS_EN, drop_count=1 and max_count=16.
REQ-035 SHALL cover full simultaneity: with full=1, assert wr_en=1 (8'h55) and rd_ack=1 together -> count=16, overflow=0, and 8'h55 is read last.
REQ-036 SHALL cover empty simultaneity: with empty=1, assert wr_en=1 (8'h3C) and rd_ack=1 together -> count=1, rd_data=8'h3C.
REQ-037 SHALL cover reset mid-operation: with count=7 and overflow=1, assert rst together with wr_en -> count=0, empty=1, overflow=0, and the byte is not stored.
